// File: rtl/usrt_rx.sv
// usrt_rx: synchronous serial receiver, one bit per CLOCK, no oversampling.
// Frame on SI: start (0), DATA_BITS data bits LSB first, stop (1); idle line is 1.
// Handshake: RX_VALID rises when a correctly framed byte lands in Rx_Data and
// stays high until the consumer pulses READ for one cycle. READ also clears
// OVERRUN and FRAME_ERR. A flag being set in the same cycle as READ stays set.
// dbg_state_o exposes the deframer state (HUNT=0, IDLE=1, DATA=2, STOP=3).
module usrt_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 SI,
  input  logic                 READ,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 RX_VALID,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    IDLE = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  // Next-state, datapath and flag logic; a completion or error overrides READ's clear
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = READ ? 1'b0 : valid_q;
    ferr_d  = READ ? 1'b0 : ferr_q;
    ovr_d   = READ ? 1'b0 : ovr_q;
    case (state_q)
      HUNT: begin
        // After reset or a framing error, wait for the line to go idle
        if (SI) state_d = IDLE;
      end
      IDLE: begin
        if (!SI) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d = {SI, shift_q[DATA_BITS-1:1]};
        if (cnt_q == CW'(DATA_BITS - 1)) state_d = STOP;
        else                             cnt_d   = cnt_q + CW'(1);
      end
      STOP: begin
        if (SI) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          // Newest frame overwrites; an unread previous byte is an overrun
          if (valid_q && !READ) ovr_d = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
    busy_d = (state_d == DATA) || (state_d == STOP);
  end

  // State and output registers
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= HUNT;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign Rx_Data     = data_q;
  assign RX_VALID    = valid_q;
  assign FRAME_ERR   = ferr_q;
  assign OVERRUN     = ovr_q;
  assign BUSY        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_usrt_rx.sv
// Directed bench for usrt_rx: a frame table plus hand-written corner sequences.
module tb_usrt_rx;

  logic       clk;
  logic       rst;
  logic       si;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [1:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  usrt_rx #(.DATA_BITS(8)) dut (
    .CLOCK      (clk),
    .RESET      (rst),
    .SI         (si),
    .READ       (rd),
    .Rx_Data    (rx_data),
    .RX_VALID   (rx_valid),
    .FRAME_ERR  (frame_err),
    .OVERRUN    (overrun),
    .BUSY       (busy),
    .dbg_state_o(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd_stop;
    logic       rd_after;
    logic [7:0] exp_d;
    logic       exp_v;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] d, input logic v,
                           input logic fe, input logic ov);
    check({name, ".data"},  rx_data, d);
    check({name, ".valid"}, {7'd0, rx_valid}, {7'd0, v});
    check({name, ".ferr"},  {7'd0, frame_err}, {7'd0, fe});
    check({name, ".ovr"},   {7'd0, overrun}, {7'd0, ov});
  endtask

  // Drive one bit for one clock; outputs are sampled 1 time unit after the edge
  task automatic tick(input logic s, input logic r);
    si = s;
    rd = r;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  // Start bit, 8 data bits LSB first, then the given stop bit with optional READ
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic r_stop);
    tick(1'b0, 1'b0);
    check("busy_start", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 8; i++) tick(d[i], 1'b0);
    tick(stop, r_stop);
    check("busy_stop", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    //            data   stop  rdS   rdA   exp_d  v     fe    ov
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h99, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0};

    // Reset with idle line
    rst = 1'b1;
    si  = 1'b1;
    rd  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.busy", {7'd0, busy}, 8'd0);
    check("reset.state", {6'd0, dbg_state}, 8'd0);

    // Table: one idle cycle, frame, optional READ pulse afterwards
    for (int k = 0; k < 9; k++) begin
      tick(1'b1, 1'b0);
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].rd_stop);
      check_out($sformatf("vec%0d", k), vecs[k].exp_d, vecs[k].exp_v,
                vecs[k].exp_fe, vecs[k].exp_ov);
      if (vecs[k].rd_after) begin
        tick(1'b1, 1'b1);
        check_out($sformatf("vec%0d_rd", k), vecs[k].exp_d, 1'b0, 1'b0, 1'b0);
      end
    end

    // Framing error, then a held-low line must not start a frame
    tick(1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    check_out("ferr", 8'h7E, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check("hunt.busy", {7'd0, busy}, 8'd0);
      check("hunt.state", {6'd0, dbg_state}, 8'd0);
    end
    tick(1'b1, 1'b0);
    send_frame(8'h3A, 1'b1, 1'b0);
    check_out("after_hunt", 8'h3A, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check_out("after_hunt_rd", 8'h3A, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames, READ on the second frame's start bit
    send_frame(8'h3C, 1'b1, 1'b0);
    check_out("b2b_0", 8'h3C, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("b2b.rd_valid", {7'd0, rx_valid}, 8'd0);
    check("b2b.busy", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 8; i++) tick(8'hC3 >> i, 1'b0);
    tick(1'b1, 1'b0);
    check_out("b2b_1", 8'hC3, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check_out("b2b_rd", 8'hC3, 1'b0, 1'b0, 1'b0);

    // Async reset in mid-frame with a byte pending
    send_frame(8'hAA, 1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("midrst.busy", {7'd0, busy}, 8'd0);
    check("midrst.state", {6'd0, dbg_state}, 8'd0);
    si = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    check_out("post_rst", 8'hFF, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
